// File: rtl/rsa_pkg.sv
// Shared types for the modular-exponentiation sequencer: Montgomery command
// codes, sequencer FSM states and the per-command issue/wait phase.
package rsa_pkg;

    typedef enum logic [1:0] {
        OP_TO_MONT   = 2'b00,
        OP_MULT      = 2'b01,
        OP_SQUARE    = 2'b10,
        OP_FROM_MONT = 2'b11
    } mm_op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TO_MONT,
        ST_LOOP_SQ,
        ST_LOOP_MUL,
        ST_FROM_MONT,
        ST_FINISH
    } state_e;

    typedef enum logic {
        PH_ISSUE,
        PH_WAIT
    } phase_e;

    // Command presented to the core in each state; idle states park on TO_MONT.
    function automatic mm_op_e op_for_state(input state_e s);
        case (s)
            ST_LOOP_SQ:   return OP_SQUARE;
            ST_LOOP_MUL:  return OP_MULT;
            ST_FROM_MONT: return OP_FROM_MONT;
            default:      return OP_TO_MONT;
        endcase
    endfunction

    function automatic logic is_op_state(input state_e s);
        return (s == ST_TO_MONT) || (s == ST_LOOP_SQ) ||
               (s == ST_LOOP_MUL) || (s == ST_FROM_MONT);
    endfunction

endpackage

// File: rtl/rsa_exp_scanner.sv
// Latched exponent plus MSB-first bit index; reports the current exponent bit
// and whether the index has reached bit 0.
module rsa_exp_scanner
    import rsa_pkg::*;
#(
    parameter int E_WIDTH = 32,
    parameter int LEN_W   = 6
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               load,
    input  logic               dec,
    input  logic [E_WIDTH-1:0] exp_in,
    input  logic [LEN_W-1:0]   exp_len,
    output logic [LEN_W-1:0]   bit_idx,
    output logic               cur_bit,
    output logic               last_bit
);

    logic [E_WIDTH-1:0] exp_q;
    logic [LEN_W-1:0]   idx_q;
    logic [E_WIDTH-1:0] exp_shifted;

    // NOTE: state registers use non-blocking assignment so every flop samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            exp_q <= '0;
            idx_q <= '0;
        end else if (load) begin
            exp_q <= exp_in;
            idx_q <= (exp_len == '0) ? '0 : exp_len - LEN_W'(1);
        end else if (dec && (idx_q != '0)) begin
            idx_q <= idx_q - LEN_W'(1);
        end
    end

    // Shift instead of a variable part-select: idx_q is wider than a bit index.
    assign exp_shifted = exp_q >> idx_q;
    assign cur_bit     = exp_shifted[0];
    assign last_bit    = (idx_q == '0);
    assign bit_idx     = idx_q;

endmodule

// File: rtl/rsa_exp_sequencer.sv
// Left-to-right square-and-multiply sequencer driving the Montgomery core's
// command/done handshake; operand routing in the datapath follows mm_op.
module rsa_exp_sequencer
    import rsa_pkg::*;
#(
    parameter int E_WIDTH = 32,
    parameter int LEN_W   = 6
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               start,
    input  logic               abort,
    input  logic [E_WIDTH-1:0] exp_in,
    input  logic [LEN_W-1:0]   exp_len,
    output logic               mm_start,
    output logic [1:0]         mm_op,
    input  logic               mm_done,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [LEN_W-1:0]   bit_idx
);

    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(E_WIDTH);

    state_e state_q, state_d;
    phase_e phase_q, phase_d;
    logic   err_q, err_d;
    logic   load, dec;
    logic   cur_bit, last_bit;
    logic   in_op;

    rsa_exp_scanner #(
        .E_WIDTH (E_WIDTH),
        .LEN_W   (LEN_W)
    ) u_scanner (
        .clk      (clk),
        .resetn   (resetn),
        .load     (load),
        .dec      (dec),
        .exp_in   (exp_in),
        .exp_len  (exp_len),
        .bit_idx  (bit_idx),
        .cur_bit  (cur_bit),
        .last_bit (last_bit)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            phase_q <= PH_ISSUE;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            err_q   <= err_d;
        end
    end

    assign in_op = is_op_state(state_q);

    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        load    = 1'b0;
        dec     = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    if (exp_len > MAX_LEN) begin
                        err_d = 1'b1;
                    end else begin
                        load    = 1'b1;
                        phase_d = PH_ISSUE;
                        state_d = (exp_len == '0) ? ST_FROM_MONT : ST_TO_MONT;
                    end
                end
            end

            ST_FINISH: state_d = ST_IDLE;

            default: begin
                // A done pulse during ISSUE cannot belong to this command.
                if (phase_q == PH_ISSUE) begin
                    phase_d = PH_WAIT;
                end else if (mm_done) begin
                    phase_d = PH_ISSUE;
                    case (state_q)
                        ST_TO_MONT: state_d = ST_LOOP_SQ;
                        ST_LOOP_SQ: begin
                            if (cur_bit)       state_d = ST_LOOP_MUL;
                            else if (last_bit) state_d = ST_FROM_MONT;
                            else               dec     = 1'b1;
                        end
                        ST_LOOP_MUL: begin
                            if (last_bit) begin
                                state_d = ST_FROM_MONT;
                            end else begin
                                dec     = 1'b1;
                                state_d = ST_LOOP_SQ;
                            end
                        end
                        ST_FROM_MONT: state_d = ST_FINISH;
                        default: ;
                    endcase
                end
            end
        endcase

        // Abort outranks a coincident mm_done; the core itself is not told.
        if (abort && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
            phase_d = PH_ISSUE;
            dec     = 1'b0;
        end
    end

    assign mm_start = in_op && (phase_q == PH_ISSUE);
    assign mm_op    = op_for_state(state_q);
    assign busy     = in_op;
    assign done     = (state_q == ST_FINISH);
    assign err      = err_q;

endmodule

// File: doc/rsa_exp_sequencer.md
Name: rsa_exp_sequencer

Overview:
Hardware sequencer for left-to-right square-and-multiply modular exponentiation on the existing Montgomery multiplier core. It replaces the software loop that currently issues to-Montgomery, square, multiply and from-Montgomery commands one at a time over AXI-Lite. It sits between the CSR block (start, exponent, length) and the multiplier's command/done handshake; operand and result routing stay in the datapath and are selected by mm_op.

Parameters:
E_WIDTH, 32, maximum exponent width in bits
LEN_W, 6, width of exp_len; must satisfy 2^LEN_W > E_WIDTH

Ports:
clk  in  1  system clock
resetn  in  1  synchronous active-low reset
start  in  1  one-cycle request; sampled only in IDLE
abort  in  1  synchronous cancel of the current run
exp_in  in  E_WIDTH  exponent; bit exp_len-1 is processed first
exp_len  in  LEN_W  number of exponent bits to process (0..E_WIDTH)
mm_start  out  1  one-cycle command strobe to the Montgomery core
mm_op  out  2  command code; valid and stable while the core is busy
mm_done  in  1  one-cycle completion pulse from the core
busy  out  1  high from the cycle after an accepted start until done or abort
done  out  1  one-cycle pulse; result is in the datapath A register
err  out  1  one-cycle pulse when start has exp_len > E_WIDTH
bit_idx  out  LEN_W  index of the exponent bit currently being processed (debug/CSR)

Behaviour:
- Reset (resetn=0 at a rising edge): state=IDLE. mm_start, busy, done and err are 0; mm_op=TO_MONT; bit_idx=0. Reset aborts any run at once; a pending mm_done after reset is ignored.
- The FSM has states IDLE, TO_MONT, LOOP_SQ, LOOP_MUL, FROM_MONT and FINISH. Each op state has two phases:
  - ISSUE: mm_start=1 for exactly 1 cycle, with mm_op set.
  - WAIT: hold mm_op and wait for mm_done.
- Accepting start in IDLE at cycle t:
  - Latch exp_in and exp_len.
  - If exp_len > E_WIDTH: pulse err at t+1 and stay in IDLE. busy stays 0 and no mm_start is issued.
  - If exp_len == 0: go straight to FROM_MONT (A already holds R mod N, so the result is 1). mm_start is issued at t+1.
  - Otherwise go to TO_MONT with mm_start at t+1 and bit_idx=exp_len-1.
- TO_MONT: the core computes X~ = MontMul(M, R^2 mod N). mm_done -> LOOP_SQ.
- LOOP_SQ (op SQUARE, A = MontMul(A, A)). On mm_done:
  - If exp[bit_idx]=1 -> LOOP_MUL.
  - Else if bit_idx==0 -> FROM_MONT.
  - Else decrement bit_idx and stay in LOOP_SQ.
- LOOP_MUL (op MULT, A = MontMul(A, X~)). On mm_done:
  - If bit_idx==0 -> FROM_MONT.
  - Else decrement bit_idx -> LOOP_SQ.
- FROM_MONT (op FROM_MONT, A = MontMul(A, 1)). mm_done at cycle v -> FINISH. done=1 at v+1 and busy=0 at v+1, then the FSM returns to IDLE.
- Latency:
  - mm_done at cycle u -> next mm_start at u+1 (zero bubble beyond the registered strobe).
  - Total commands = 2 + exp_len + popcount(exp[exp_len-1:0]). The exp_len==0 case issues exactly 1 command.
- Handshake rules:
  - mm_done outside a WAIT phase is ignored.
  - mm_done coinciding with the ISSUE cycle is ignored, because the core cannot finish in 0 cycles.
  - start while busy is ignored, and the latched exponent is not modified.
- abort has priority over mm_done in the same cycle. The FSM goes to IDLE next cycle with busy=0 and no done pulse. The core is not signalled; software must wait for core idle before restarting.
- abort and start asserted together in IDLE: abort wins and the start is dropped.
- mm_op encodings: TO_MONT=2'b00, MULT=2'b01, SQUARE=2'b10, FROM_MONT=2'b11.

Decomposition:
- Shared package rsa_pkg holds:
  - the mm_op encodings,
  - the FSM state enum,
  - the phase enum (ISSUE/WAIT).
- One sub-module, rsa_exp_scanner, holds the latched exponent, the bit_idx down-counter, the current-bit output and the last-bit flag. Its inputs are load and dec.
- The top level keeps the FSM and the handshake logic.

Test Plan:
- exp_in=0x9985, exp_len=16, model core with 5-cycle latency -> exactly 25 mm_start pulses. Op sequence begins TO_MONT, SQUARE, MULT, SQUARE, SQUARE, SQUARE, MULT and ends MULT, FROM_MONT. done occurs once, 1 cycle after the last mm_done.
- exp_len=0 -> single FROM_MONT command, then done; busy high for 1 + core latency + 1 cycles.
- exp_len=33 with E_WIDTH=32 -> err pulse at t+1, busy stays 0, no mm_start.
- abort asserted during the 4th WAIT, same cycle as mm_done -> no further mm_start, busy=0 next cycle, done never pulses. A following start runs normally.
- start re-pulsed mid-run, and a spurious mm_done in ISSUE or IDLE -> command sequence identical to an undisturbed run.
- resetn=0 for 1 cycle during LOOP_MUL -> all outputs return to reset values next cycle; the core's late mm_done is ignored.
